// File: rtl/red_pitaya_iq_pkg.sv
// Shared definitions for the IQ decimator: default depth, accumulator sizing
// and the clamp applied to the requested log2 decimation factor.
package red_pitaya_iq_pkg;

  localparam int INBITS_DEF = 18;
  localparam int MAXLOG_DEF = 10;
  localparam int ACC_W_DEF  = INBITS_DEF + MAXLOG_DEF;

  // Room for 2^maxlog full-scale samples without wrap.
  function automatic int acc_width(input int inbits, input int maxlog);
    return inbits + maxlog;
  endfunction

  function automatic int clamp_log2(input int req, input int maxlog);
    return (req > maxlog) ? maxlog : req;
  endfunction

endpackage

// File: rtl/red_pitaya_iq_accu_channel.sv
// One decimator channel: boxcar accumulator, floor-mean shifter and the
// registered output word.
module red_pitaya_iq_accu_channel
  import red_pitaya_iq_pkg::*;
#(
  parameter int INBITS  = 18,
  parameter int OUTBITS = 18,
  parameter int MAXLOG  = MAXLOG_DEF,
  parameter int NW      = 4
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      clr_i,
  input  logic                      term_i,
  input  logic [NW-1:0]             n_i,
  input  logic signed [INBITS-1:0]  sample_i,
  output logic signed [OUTBITS-1:0] out_o
);

  localparam int ACC_W = acc_width(INBITS, MAXLOG);

  logic signed [ACC_W-1:0]   acc_p0;
  logic signed [ACC_W-1:0]   sum_p0;
  logic signed [OUTBITS-1:0] out_p1;

  // Arithmetic shift floors toward -inf; the mean always fits INBITS, so
  // keeping the top OUTBITS of that field needs no saturation.
  function automatic logic signed [OUTBITS-1:0] mean_trunc(
    input logic signed [ACC_W-1:0] s,
    input logic [NW-1:0]           n
  );
    logic signed [ACC_W-1:0] m;
    m = s >>> n;
    return OUTBITS'(m >>> (INBITS - OUTBITS));
  endfunction

  assign sum_p0 = acc_p0 + ACC_W'(sample_i);

  // Stage p0 -> p1: accumulate, or dump the window mean into the output register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      acc_p0 <= '0;
      out_p1 <= '0;
    end else if (clr_i) begin
      acc_p0 <= '0;
    end else if (term_i) begin
      acc_p0 <= '0;
      out_p1 <= mean_trunc(sum_p0, n_i);
    end else begin
      acc_p0 <= sum_p0;
    end
  end

  assign out_o = out_p1;

endmodule

// File: rtl/red_pitaya_iq_decimator_block.sv
// Accumulate-and-dump decimator for the demodulator sin/cos product streams;
// averages 2^N samples per channel and strobes valid_o once per window.
module red_pitaya_iq_decimator_block
  import red_pitaya_iq_pkg::*;
#(
  parameter int INBITS  = 18,
  parameter int OUTBITS = 18,
  parameter int MAXLOG  = MAXLOG_DEF,
  parameter int LOGBITS = 4
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [LOGBITS-1:0]        log2_dec_i,
  input  logic                      sync_i,
  input  logic signed [INBITS-1:0]  signal1_i,
  input  logic signed [INBITS-1:0]  signal2_i,
  output logic signed [OUTBITS-1:0] signal1_o,
  output logic signed [OUTBITS-1:0] signal2_o,
  output logic                      valid_o
);

  localparam int NW = $clog2(MAXLOG + 1);

  logic [MAXLOG-1:0] cnt_p0;
  logic [MAXLOG-1:0] last_cnt;
  logic [NW-1:0]     n_q;
  logic [NW-1:0]     n_req;
  logic [NW-1:0]     n_eff;
  logic              start;
  logic              term;
  logic              vld_p1;

  assign n_req = NW'(clamp_log2(int'(log2_dec_i), MAXLOG));

  // A new N is only honoured on the first sample of a window.
  always_comb begin
    start    = (cnt_p0 == '0);
    n_eff    = start ? n_req : n_q;
    last_cnt = ~({MAXLOG{1'b1}} << n_eff);
    term     = (cnt_p0 == last_cnt);
  end

  // Stage p0 -> p1: window counter and valid strobe; sync wins over term
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_p0 <= '0;
      n_q    <= '0;
      vld_p1 <= 1'b0;
    end else begin
      if (start) n_q <= n_req;
      if (sync_i) begin
        cnt_p0 <= '0;
        vld_p1 <= 1'b0;
      end else if (term) begin
        cnt_p0 <= '0;
        vld_p1 <= 1'b1;
      end else begin
        cnt_p0 <= cnt_p0 + 1'b1;
        vld_p1 <= 1'b0;
      end
    end
  end

  red_pitaya_iq_accu_channel #(
    .INBITS (INBITS),
    .OUTBITS(OUTBITS),
    .MAXLOG (MAXLOG),
    .NW     (NW)
  ) u_ch1 (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clr_i   (sync_i),
    .term_i  (term),
    .n_i     (n_eff),
    .sample_i(signal1_i),
    .out_o   (signal1_o)
  );

  red_pitaya_iq_accu_channel #(
    .INBITS (INBITS),
    .OUTBITS(OUTBITS),
    .MAXLOG (MAXLOG),
    .NW     (NW)
  ) u_ch2 (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clr_i   (sync_i),
    .term_i  (term),
    .n_i     (n_eff),
    .sample_i(signal2_i),
    .out_o   (signal2_o)
  );

  assign valid_o = vld_p1;

endmodule

// File: tb/tb_red_pitaya_iq_decimator_block.sv
// Directed/random bench for the IQ decimator against a sample-window model.
module tb_red_pitaya_iq_decimator_block;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic [3:0]               log2_dec = 4'd0;
  logic                     sync = 1'b0;
  logic signed [17:0]       x1 = '0;
  logic signed [17:0]       x2 = '0;
  logic signed [17:0]       y1;
  logic signed [17:0]       y2;
  logic                     vld;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state: samples collected in the open window
  int      m_cnt = 0;
  int      m_n   = 0;
  longint  m_s1  = 0;
  longint  m_s2  = 0;
  logic signed [17:0] e1 = '0;
  logic signed [17:0] e2 = '0;
  logic               ev = 1'b0;
  int      pulses = 0;

  always #5 clk = ~clk;

  red_pitaya_iq_decimator_block dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .log2_dec_i(log2_dec),
    .sync_i    (sync),
    .signal1_i (x1),
    .signal2_i (x2),
    .signal1_o (y1),
    .signal2_o (y2),
    .valid_o   (vld)
  );

  function automatic longint floor_div(input longint s, input longint d);
    longint q;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_s1 = 0; m_s2 = 0; m_n = 0;
    e1 = '0; e2 = '0; ev = 1'b0;
  endtask

  // Model of one clock: the window size is fixed by the request seen at its first sample.
  task automatic model_clock();
    if (sync) begin
      m_cnt = 0; m_s1 = 0; m_s2 = 0; ev = 1'b0;
    end else begin
      if (m_cnt == 0) m_n = (int'(log2_dec) > 10) ? 10 : int'(log2_dec);
      m_s1 += longint'(x1);
      m_s2 += longint'(x2);
      m_cnt++;
      if (m_cnt == (1 << m_n)) begin
        e1 = 18'(floor_div(m_s1, longint'(1) << m_n));
        e2 = 18'(floor_div(m_s2, longint'(1) << m_n));
        ev = 1'b1;
        m_cnt = 0; m_s1 = 0; m_s2 = 0;
      end else begin
        ev = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_clock();
    if (ev) pulses++;
    chk("valid", longint'(vld), longint'(ev));
    chk("out1", longint'(y1), longint'(e1));
    chk("out2", longint'(y2), longint'(e2));
  endtask

  task automatic rnd_inputs();
    x1 = 18'($urandom);
    x2 = 18'($urandom);
  endtask

  initial begin
    int p0;
    // reset state
    #2;
    chk("rst_valid", longint'(vld), 0);
    chk("rst_out1", longint'(y1), 0);
    chk("rst_out2", longint'(y2), 0);

    // N=2, constant 1000: first pulse 4 cycles after release
    @(posedge clk); #1;
    log2_dec = 4'd2; x1 = 18'sd1000; x2 = 18'sd1000;
    rstn = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step();
    chk("first_pulse_early", longint'(vld), 0);
    step();
    chk("first_pulse", longint'(vld), 1);
    chk("const1", longint'(y1), 1000);
    chk("const2", longint'(y2), 1000);
    for (int i = 0; i < 8; i++) step();

    // N=2 ramp / negative floor
    for (int i = 0; i < 4; i++) begin
      x1 = 18'(i);
      x2 = (i == 3) ? -18'sd2 : -18'sd1;
      step();
    end
    chk("ramp_v", longint'(vld), 1);
    chk("ramp1", longint'(y1), 1);
    chk("ramp2", longint'(y2), -2);

    // N=10 full-scale, no wrap
    log2_dec = 4'd10; x1 = 18'sd131071; x2 = -18'sd131072;
    for (int i = 0; i < 1024; i++) step();
    chk("fs_v", longint'(vld), 1);
    chk("fs1", longint'(y1), 131071);
    chk("fs2", longint'(y2), -131072);

    // N=0 random: registered pass-through
    log2_dec = 4'd0;
    for (int i = 0; i < 20; i++) begin
      rnd_inputs();
      step();
      chk("n0_valid_high", longint'(vld), 1);
    end

    // N=3 with mid-window change to 1: window still 8 long
    log2_dec = 4'd3;
    p0 = pulses;
    for (int i = 0; i < 3; i++) begin rnd_inputs(); step(); end
    log2_dec = 4'd1;
    for (int i = 0; i < 5; i++) begin rnd_inputs(); step(); end
    chk("win8_pulses", longint'(pulses - p0), 1);
    chk("win8_v", longint'(vld), 1);
    p0 = pulses;
    for (int i = 0; i < 6; i++) begin rnd_inputs(); step(); end
    chk("win2_pulses", longint'(pulses - p0), 3);

    // N=3 window abandoned by sync at cnt=5
    log2_dec = 4'd3;
    for (int i = 0; i < 5; i++) begin rnd_inputs(); step(); end
    sync = 1'b1; rnd_inputs(); step();
    chk("sync_nopulse", longint'(vld), 0);
    sync = 1'b0;
    for (int i = 0; i < 8; i++) begin rnd_inputs(); step(); end
    chk("post_sync_v", longint'(vld), 1);

    // N=1: sync coinciding with term
    log2_dec = 4'd1;
    rnd_inputs(); step();
    sync = 1'b1; rnd_inputs(); step();
    chk("sync_term_nopulse", longint'(vld), 0);
    sync = 1'b0;
    for (int i = 0; i < 4; i++) begin rnd_inputs(); step(); end

    // N=3 reset at cnt=6, then clamped N=15 -> 1024 samples
    log2_dec = 4'd3;
    for (int i = 0; i < 6; i++) begin rnd_inputs(); step(); end
    rstn = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", longint'(vld), 0);
    chk("arst_out1", longint'(y1), 0);
    chk("arst_out2", longint'(y2), 0);
    @(posedge clk); #1;
    log2_dec = 4'd15;
    rstn = 1'b1;
    p0 = pulses;
    for (int i = 0; i < 1023; i++) begin rnd_inputs(); step(); end
    chk("clamp_no_early", longint'(pulses - p0), 0);
    rnd_inputs(); step();
    chk("clamp_pulse", longint'(vld), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/red_pitaya_iq_decimator_block.md
# red_pitaya_iq_decimator_block

Boxcar accumulate-and-dump decimator for the two product streams produced by the IQ demodulator block (sin-product and cos-product channels). It sits directly downstream of the demodulator. Every clock it takes one 18-bit sample per channel, averages 2^N consecutive samples, and emits one decimated I/Q pair with a single-cycle valid strobe. N is runtime-programmable. The block is the first low-pass/rate-reduction stage ahead of the scope and IQ-output paths.

## Interface
- INBITS, 18, width of each input channel (matches the demodulator OUTBITS)
- OUTBITS, 18, width of each output channel; must be ≤ INBITS
- MAXLOG, 10, largest supported log2 decimation factor
- LOGBITS, 4, width of the log2_dec_i port
- clk_i  in  1  system clock (single clock domain)
- rstn_i  in  1  reset, asynchronous, active-low
- log2_dec_i  in  LOGBITS  requested N; values above MAXLOG are clamped to MAXLOG
- sync_i  in  1  restart: discard the partial window and start a new one
- signal1_i  in  INBITS signed  sin-product sample, one per clock
- signal2_i  in  INBITS signed  cos-product sample, one per clock
- signal1_o  out  OUTBITS signed  decimated channel 1
- signal2_o  out  OUTBITS signed  decimated channel 2
- valid_o  out  1  one-cycle pulse; signal1_o/signal2_o are new in this cycle

## Operation
- State: window counter cnt (MAXLOG bits), latched n_q, one accumulator per channel (acc1, acc2), each INBITS+MAXLOG bits signed.
- start = (cnt == 0). N_eff = start ? clamp(log2_dec_i) : n_q. When start is high, n_q <= clamp(log2_dec_i).
- A log2_dec_i change mid-window takes effect only at the next window start.
- term = (cnt == 2^N_eff − 1).
- Not term: acc <= acc + sign-extended input; cnt <= cnt + 1.
- Term:
  - sum = acc + input;
  - mean = sum >>> N_eff (arithmetic shift, floor rounding);
  - out <= mean[INBITS-1 : INBITS-OUTBITS];
  - acc <= 0; cnt <= 0; valid_o <= 1.
- mean always fits INBITS, so the block has no saturation logic.
- N = 0: start and term coincide every cycle. The block becomes a registered pass-through with valid_o held high.
- sync_i high: acc <= 0, cnt <= 0, valid_o <= 0. The current sample is discarded. sync_i takes priority over term: no valid pulse in a cycle where both are high. n_q is reloaded at the next start.
- Outputs hold their last value between valid pulses.
- Both channels share cnt, n_q and valid_o. They are always aligned.

## Timing
- Reset values: signal1_o = 0, signal2_o = 0, valid_o = 0, cnt = 0, acc1 = acc2 = 0, n_q = 0.
- Reset is asynchronous. Asserting rstn_i mid-window abandons the window. The first sample after reset release is the first sample of a new window.
- Latency: the output is registered one cycle after the last sample of a window is presented, so valid_o rises in cycle t+1 when term occurs in cycle t.
- Throughput: one output per 2^N input cycles, with no gaps between windows.
- After sync_i is high in cycle t, the sample in cycle t+1 is sample 0 of a new window.

## Structure
- Shared package `red_pitaya_iq_pkg` holds:
  - MAXLOG default;
  - accumulator width (INBITS+MAXLOG);
  - the clamp function for log2_dec_i.
- Sub-module `red_pitaya_iq_accu_channel` holds one accumulator, the shifter and the output register. It is instantiated twice.
- The top level holds cnt, n_q, start/term decode and valid_o.

## Test plan
- N=2, both inputs constant 1000 → outputs 1000, valid_o pulses every 4th cycle; first pulse is 4 cycles after reset release.
- N=2, ch1 ramp 0,1,2,3 → 1 (floor of 1.5); ch2 −1,−1,−1,−2 → −2 (floor of −1.25).
- N=10, ch1 all 131071, ch2 all −131072 → 131071 and −131072 exactly, with no wrap.
- N=0, random inputs → outputs equal inputs delayed 1 cycle; valid_o high continuously.
- N=3: switch log2_dec_i to 1 at cnt=3, then assert sync_i at cnt=5.
  - The current window stays 8 samples long.
  - sync_i at cnt=5 yields no pulse.
  - Subsequent windows are 2 samples long.
  - sync_i coinciding with term also produces no pulse.
- rstn_i low mid-window at cnt=6 → outputs and valid_o at 0 immediately. After release with log2_dec_i=15 (clamped to 10), the first pulse arrives after 1024 samples.
